local_cycle_terminator: RTL and testbench

//  Responder side of the 68030 local bus cycle. It terminates CPU cycles aimed at the on-board ROM, RAM and serial

---
 rtl/local_cycle_terminator.sv | 147 ++++++++++++++
 tb/tb_local_cycle_terminator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_cycle_terminator.sv
// Responder for 68030 local bus cycles: terminates ROM/RAM/serial accesses with sized DSACK
// after per-device wait states, and raises BERR on unmapped or unterminated cycles.
module local_cycle_terminator #(
    parameter logic [3:0] ROM_WAIT    = 4'd2,
    parameter logic [3:0] RAM_WAIT    = 4'd0,
    parameter logic [3:0] SERIAL_WAIT = 4'd4,
    parameter logic [1:0] ROM_SIZE    = 2'b01,
    parameter logic [1:0] RAM_SIZE    = 2'b00,
    parameter logic [1:0] SERIAL_SIZE = 2'b10,
    parameter logic [7:0] TIMEOUT     = 8'd255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_as,
    input  logic       cpu_ds,
    input  logic       request_rom,
    input  logic       request_ram,
    input  logic       request_serial,
    input  logic       request_unmapped,
    input  logic       ext_term,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_TMO,
        S_BERR,
        S_END
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic [7:0] count_next;
    logic [1:0] size;
    logic [1:0] size_next;
    logic [1:0] dsack_next;
    logic       berr_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            count     <= 8'd0;
            size      <= 2'b11;
            cpu_dsack <= 2'b11;
            cpu_berr  <= 1'b1;
        end else begin
            state     <= state_next;
            count     <= count_next;
            size      <= size_next;
            cpu_dsack <= dsack_next;
            cpu_berr  <= berr_next;
        end
    end

    // Outputs are computed here and registered above, so no input reaches a pin combinationally.
    always_comb begin
        state_next = state;
        count_next = count;
        size_next  = size;
        dsack_next = cpu_dsack;
        berr_next  = cpu_berr;

        case (state)
            S_IDLE: begin
                dsack_next = 2'b11;
                berr_next  = 1'b1;
                if (!cpu_as) begin
                    if (!request_unmapped) begin
                        state_next = S_BERR;
                    end else if (!request_rom) begin
                        state_next = S_WAIT;
                        count_next = {4'd0, ROM_WAIT};
                        size_next  = ROM_SIZE;
                    end else if (!request_ram) begin
                        state_next = S_WAIT;
                        count_next = {4'd0, RAM_WAIT};
                        size_next  = RAM_SIZE;
                    end else if (!request_serial) begin
                        state_next = S_WAIT;
                        count_next = {4'd0, SERIAL_WAIT};
                        size_next  = SERIAL_SIZE;
                    end else begin
                        state_next = S_TMO;
                        count_next = 8'd1;
                    end
                end
            end

            // Wait states run down regardless of DS; the acknowledge itself waits for DS.
            S_WAIT: begin
                if (cpu_as) begin
                    state_next = S_IDLE;
                end else if (count != 8'd0) begin
                    count_next = count - 8'd1;
                end else if (!cpu_ds) begin
                    state_next = S_ACK;
                    dsack_next = size;
                end
            end

            S_ACK: begin
                if (cpu_as) begin
                    state_next = S_IDLE;
                    dsack_next = 2'b11;
                end
            end

            S_TMO: begin
                if (cpu_as) begin
                    state_next = S_IDLE;
                end else if (!ext_term) begin
                    state_next = S_END;
                end else if (count >= TIMEOUT) begin
                    state_next = S_BERR;
                end else if (count != 8'hFF) begin
                    count_next = count + 8'd1;
                end
            end

            S_BERR: begin
                if (cpu_as) begin
                    state_next = S_IDLE;
                    berr_next  = 1'b1;
                end else begin
                    berr_next  = 1'b0;
                end
            end

            S_END: begin
                if (cpu_as) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
                dsack_next = 2'b11;
                berr_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_local_cycle_terminator.sv
// Bench for local_cycle_terminator: per-scenario tasks push expected {dsack,berr} per clock
// into a scoreboard queue and compare after each edge.
module tb_local_cycle_terminator;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_as = 1'b1;
    logic       cpu_ds = 1'b1;
    logic       request_rom = 1'b1;
    logic       request_ram = 1'b1;
    logic       request_serial = 1'b1;
    logic       request_unmapped = 1'b1;
    logic       ext_term = 1'b1;
    logic [1:0] cpu_dsack;
    logic       cpu_berr;

    typedef struct packed {
        logic [1:0] dsack;
        logic       berr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    local_cycle_terminator #(
        .TIMEOUT(8'd8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu_as(cpu_as),
        .cpu_ds(cpu_ds),
        .request_rom(request_rom),
        .request_ram(request_ram),
        .request_serial(request_serial),
        .request_unmapped(request_unmapped),
        .ext_term(ext_term),
        .cpu_dsack(cpu_dsack),
        .cpu_berr(cpu_berr)
    );

    always #5 clock = ~clock;

    task automatic idle_bus();
        cpu_as           = 1'b1;
        cpu_ds           = 1'b1;
        request_rom      = 1'b1;
        request_ram      = 1'b1;
        request_serial   = 1'b1;
        request_unmapped = 1'b1;
        ext_term         = 1'b1;
    endtask

    task automatic test_reset();
        exp_t want, got;
        #1;
        reset = 1'b0;
        sb.push_back('{dsack: 2'b11, berr: 1'b1});
        #1;
        got = '{dsack: cpu_dsack, berr: cpu_berr};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL reset_async: dsack=%b berr=%b, expected dsack=%b berr=%b", got.dsack, got.berr, want.dsack, want.berr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 2) reset = 1'b1;
            cpu_as           = (i < 2) ? 1'b0 : 1'b1;
            request_unmapped = (i < 2) ? 1'b0 : 1'b1;
            sb.push_back('{dsack: 2'b11, berr: 1'b1});
            @(posedge clock);
            #1;
            got = '{dsack: cpu_dsack, berr: cpu_berr};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset_hold edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", i, got.dsack, got.berr, want.dsack, want.berr);
            end
        end
        idle_bus();
    endtask

    task automatic test_ram_read();
        exp_t want, got;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clock);
            cpu_as      = (i < 5) ? 1'b0 : 1'b1;
            cpu_ds      = cpu_as;
            request_ram = 1'b0;
            sb.push_back('{dsack: (i >= 1 && i < 5) ? 2'b00 : 2'b11, berr: 1'b1});
            @(posedge clock);
            #1;
            got = '{dsack: cpu_dsack, berr: cpu_berr};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL ram_read edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", i, got.dsack, got.berr, want.dsack, want.berr);
            end
        end
        idle_bus();
    endtask

    // Requests swap after edge 0 to confirm they are only sampled in IDLE.
    task automatic test_rom_read();
        exp_t want, got;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clock);
            cpu_as      = (i < 6) ? 1'b0 : 1'b1;
            cpu_ds      = cpu_as;
            request_rom = (i == 0) ? 1'b0 : 1'b1;
            request_ram = (i == 0) ? 1'b1 : 1'b0;
            sb.push_back('{dsack: (i >= 3 && i < 6) ? 2'b01 : 2'b11, berr: 1'b1});
            @(posedge clock);
            #1;
            got = '{dsack: cpu_dsack, berr: cpu_berr};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL rom_read edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", i, got.dsack, got.berr, want.dsack, want.berr);
            end
        end
        idle_bus();
    endtask

    task automatic test_serial_write();
        exp_t want, got;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clock);
            cpu_as         = (i < 9) ? 1'b0 : 1'b1;
            cpu_ds         = (i >= 6 && i < 9) ? 1'b0 : 1'b1;
            request_serial = 1'b0;
            sb.push_back('{dsack: (i >= 6 && i < 9) ? 2'b10 : 2'b11, berr: 1'b1});
            @(posedge clock);
            #1;
            got = '{dsack: cpu_dsack, berr: cpu_berr};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL serial_write edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", i, got.dsack, got.berr, want.dsack, want.berr);
            end
        end
        idle_bus();
    endtask

    task automatic test_unmapped();
        exp_t want, got;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clock);
            cpu_as           = (i < 5) ? 1'b0 : 1'b1;
            cpu_ds           = cpu_as;
            request_unmapped = 1'b0;
            sb.push_back('{dsack: 2'b11, berr: (i >= 1 && i < 5) ? 1'b0 : 1'b1});
            @(posedge clock);
            #1;
            got = '{dsack: cpu_dsack, berr: cpu_berr};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL unmapped edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", i, got.dsack, got.berr, want.dsack, want.berr);
            end
        end
        idle_bus();
    endtask

    // Mode 0: unmapped+rom -> BERR; mode 1: rom+ram+serial -> ROM; mode 2: ram+serial -> RAM.
    task automatic test_priority();
        exp_t want, got;
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i <= 6; i++) begin
                @(negedge clock);
                cpu_as           = (i < 5) ? 1'b0 : 1'b1;
                cpu_ds           = cpu_as;
                request_unmapped = (m == 0) ? 1'b0 : 1'b1;
                request_rom      = (m <= 1) ? 1'b0 : 1'b1;
                request_ram      = (m >= 1) ? 1'b0 : 1'b1;
                request_serial   = (m >= 1) ? 1'b0 : 1'b1;
                case (m)
                    0:       want = '{dsack: 2'b11, berr: (i >= 1 && i < 5) ? 1'b0 : 1'b1};
                    1:       want = '{dsack: (i >= 3 && i < 5) ? 2'b01 : 2'b11, berr: 1'b1};
                    default: want = '{dsack: (i >= 1 && i < 5) ? 2'b00 : 2'b11, berr: 1'b1};
                endcase
                sb.push_back(want);
                @(posedge clock);
                #1;
                got = '{dsack: cpu_dsack, berr: cpu_berr};
                want = sb.pop_front();
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL priority mode %0d edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", m, i, got.dsack, got.berr, want.dsack, want.berr);
                end
            end
        end
        idle_bus();
    endtask

    // Pass 0: nobody terminates, BERR after TIMEOUT=8; pass 1: ext_term low at edge 3, no BERR.
    task automatic test_timeout();
        exp_t want, got;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i <= 13; i++) begin
                @(negedge clock);
                cpu_as   = (i < 12) ? 1'b0 : 1'b1;
                cpu_ds   = cpu_as;
                ext_term = (p == 1 && i >= 3 && i < 12) ? 1'b0 : 1'b1;
                sb.push_back('{dsack: 2'b11, berr: (p == 0 && i >= 9 && i < 12) ? 1'b0 : 1'b1});
                @(posedge clock);
                #1;
                got = '{dsack: cpu_dsack, berr: cpu_berr};
                want = sb.pop_front();
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL timeout pass %0d edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", p, i, got.dsack, got.berr, want.dsack, want.berr);
                end
            end
        end
        idle_bus();
    endtask

    // ROM cycle aborted at edge 2, then a RAM cycle accepted on the very next edge.
    task automatic test_back_to_back();
        exp_t want, got;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clock);
            cpu_as      = (i == 2 || i >= 5) ? 1'b1 : 1'b0;
            cpu_ds      = cpu_as;
            request_rom = (i < 2) ? 1'b0 : 1'b1;
            request_ram = (i >= 3) ? 1'b0 : 1'b1;
            sb.push_back('{dsack: (i == 4) ? 2'b00 : 2'b11, berr: 1'b1});
            @(posedge clock);
            #1;
            got = '{dsack: cpu_dsack, berr: cpu_berr};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL back_to_back edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", i, got.dsack, got.berr, want.dsack, want.berr);
            end
        end
        idle_bus();
    endtask

    task automatic test_reset_mid_ack();
        exp_t want, got;
        for (int i = 0; i <= 2; i++) begin
            @(negedge clock);
            cpu_as      = 1'b0;
            cpu_ds      = 1'b0;
            request_ram = 1'b0;
            sb.push_back('{dsack: (i >= 1) ? 2'b00 : 2'b11, berr: 1'b1});
            @(posedge clock);
            #1;
            got = '{dsack: cpu_dsack, berr: cpu_berr};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset_mid_ack setup edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", i, got.dsack, got.berr, want.dsack, want.berr);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        sb.push_back('{dsack: 2'b11, berr: 1'b1});
        #1;
        got = '{dsack: cpu_dsack, berr: cpu_berr};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL reset_mid_ack async: dsack=%b berr=%b, expected dsack=%b berr=%b", got.dsack, got.berr, want.dsack, want.berr);
        end
        @(negedge clock);
        reset = 1'b1;
        idle_bus();
        for (int i = 0; i <= 3; i++) begin
            @(negedge clock);
            cpu_as      = (i >= 1 && i < 3) ? 1'b0 : 1'b1;
            cpu_ds      = cpu_as;
            request_ram = 1'b0;
            sb.push_back('{dsack: (i == 2) ? 2'b00 : 2'b11, berr: 1'b1});
            @(posedge clock);
            #1;
            got = '{dsack: cpu_dsack, berr: cpu_berr};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset_mid_ack recovery edge %0d: dsack=%b berr=%b, expected dsack=%b berr=%b", i, got.dsack, got.berr, want.dsack, want.berr);
            end
        end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_rom_read();
        test_serial_write();
        test_unmapped();
        test_priority();
        test_timeout();
        test_back_to_back();
        test_reset_mid_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
